decompress_csr: RTL and testbench

- Reconstructs a dense H_OUT x W_OUT matrix from CSR arrays (val, col, row pointers), the inverse of the CSR compression stage.
- Walks the nonzeros one per cycle and builds each dense row in a row buffer.
- Emits each row over a valid/ready stream, then presents the full matrix with valid_output.
- Sits downstream of CSR storage and feeds dense consumers (conv/accumulate stages).

---
 rtl/decompress_csr.sv | 145 ++++++++++++++
 tb/tb_decompress_csr.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decompress_csr.sv
// CSR-to-dense decompressor: walks nonzeros one per cycle into a row buffer,
// streams each finished row over valid/ready, then presents the full matrix.
module decompress_csr #(
  parameter int SIZE_OUT      = 10,
  parameter int H_OUT         = 3,
  parameter int W_OUT         = 3,
  parameter int SIZE_in_DATA  = 14,
  parameter int SIZE_val_DATA = 8,
  parameter int SIZE_col_DATA = 10,
  parameter int SIZE_row_DATA = 18
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  start,
  input  logic signed [SIZE_val_DATA-1:0]       val [SIZE_OUT],
  input  logic        [SIZE_col_DATA-1:0]       col [SIZE_OUT],
  input  logic        [SIZE_row_DATA-1:0]       row [H_OUT+1],
  output logic signed [SIZE_in_DATA-1:0]        row_data [W_OUT],
  output logic [((H_OUT > 1) ? $clog2(H_OUT) : 1)-1:0] row_idx,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic signed [SIZE_in_DATA-1:0]        output_array [H_OUT][W_OUT],
  output logic                                  valid_output,
  output logic                                  busy,
  output logic                                  error
);

  localparam int RW  = (H_OUT > 1) ? $clog2(H_OUT) : 1;
  localparam int RCW = $clog2(H_OUT + 1);
  localparam int IW  = (SIZE_OUT > 1) ? $clog2(SIZE_OUT) : 1;
  localparam int CW  = (W_OUT > 1) ? $clog2(W_OUT) : 1;

  localparam logic [SIZE_col_DATA-1:0] W_LIM    = SIZE_col_DATA'(W_OUT);
  localparam logic [SIZE_row_DATA-1:0] SIZE_LIM = SIZE_row_DATA'(SIZE_OUT);
  localparam logic [RCW-1:0]           H_FULL   = RCW'(H_OUT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]                       state;
  logic [SIZE_row_DATA-1:0]         row_array [H_OUT+1];
  logic [SIZE_row_DATA-1:0]         ptr;
  logic [RCW-1:0]                   r;
  logic signed [SIZE_in_DATA-1:0]   row_buf [W_OUT];

  logic [RCW-1:0]                   r_next;
  logic [RCW-1:0]                   r_next2;
  logic [SIZE_row_DATA-1:0]         row_end;
  logic [SIZE_row_DATA-1:0]         ptr_inc;
  logic [SIZE_col_DATA-1:0]         col_cur;
  logic signed [SIZE_val_DATA-1:0]  val_cur;
  logic signed [SIZE_in_DATA-1:0]   val_ext;
  logic                             ptrs_ok;

  // r_next2 is clamped so the lookahead never indexes past the pointer table
  // on the last row; its value is unused in that case.
  always_comb begin
    r_next  = r + 1'b1;
    r_next2 = (r_next == H_FULL) ? r_next : r_next + 1'b1;
    row_end = row_array[r_next];
    ptr_inc = ptr + 1'b1;
    col_cur = col[ptr[IW-1:0]];
    val_cur = val[ptr[IW-1:0]];
    val_ext = SIZE_in_DATA'(val_cur);
  end

  always_comb begin
    ptrs_ok = (row_array[0] == '0) && (row_array[H_OUT] <= SIZE_LIM);
    for (int k = 0; k < H_OUT; k++) begin
      if (row_array[k+1] < row_array[k]) ptrs_ok = 1'b0;
    end
  end

  always_comb begin
    for (int j = 0; j < W_OUT; j++) row_data[j] = row_buf[j];
    row_idx      = r[RW-1:0];
    row_valid    = (state == S_EMIT);
    valid_output = (state == S_DONE);
    error        = (state == S_ERR);
    busy         = (state == S_LOAD) || (state == S_FILL) || (state == S_EMIT);
  end

  // Row-end checks are made one step ahead so an empty row, or the last
  // nonzero of a row, moves straight into EMIT without an idle FILL cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      r     <= '0;
      for (int k = 0; k <= H_OUT; k++) row_array[k] <= '0;
      for (int j = 0; j < W_OUT; j++) row_buf[j] <= '0;
      for (int i = 0; i < H_OUT; i++)
        for (int j = 0; j < W_OUT; j++) output_array[i][j] <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_LOAD;
            ptr   <= '0;
            r     <= '0;
            for (int k = 0; k <= H_OUT; k++) row_array[k] <= row[k];
            for (int j = 0; j < W_OUT; j++) row_buf[j] <= '0;
            for (int i = 0; i < H_OUT; i++)
              for (int j = 0; j < W_OUT; j++) output_array[i][j] <= '0;
          end
        end
        S_LOAD: begin
          if (!ptrs_ok)             state <= S_ERR;
          else if (row_end == ptr)  state <= S_EMIT;
          else                      state <= S_FILL;
        end
        S_FILL: begin
          if (ptr < row_end) begin
            if (col_cur >= W_LIM) begin
              state <= S_ERR;
            end else begin
              row_buf[col_cur[CW-1:0]] <= val_ext;
              ptr <= ptr_inc;
              if (ptr_inc == row_end) state <= S_EMIT;
            end
          end else begin
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (row_ready) begin
            output_array[r[RW-1:0]] <= row_buf;
            for (int j = 0; j < W_OUT; j++) row_buf[j] <= '0;
            r <= r_next;
            if (r_next == H_FULL)              state <= S_DONE;
            else if (row_array[r_next2] == ptr) state <= S_EMIT;
            else                               state <= S_FILL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompress_csr.sv
// Directed bench for decompress_csr: decode, backpressure, empty rows,
// malformed CSR, bad columns, duplicates, clock-enable freeze and async reset.
module tb_decompress_csr;

  localparam int SIZE_OUT = 10;
  localparam int H_OUT    = 3;
  localparam int W_OUT    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic row_ready = 1'b1;
  logic signed [7:0]  val [SIZE_OUT];
  logic        [9:0]  col [SIZE_OUT];
  logic        [17:0] row [H_OUT+1];
  logic signed [13:0] row_data [W_OUT];
  logic        [1:0]  row_idx;
  logic               row_valid;
  logic signed [13:0] output_array [H_OUT][W_OUT];
  logic               valid_output;
  logic               busy;
  logic               error;

  int checks = 0;
  int errors = 0;

  logic signed [13:0] got_data [8][W_OUT];
  logic        [1:0]  got_idx  [8];
  int                 got_edge [8];
  int                 nrows;
  int                 stall_bad;
  logic signed [13:0] exp_m [H_OUT][W_OUT];

  always #5 clk = ~clk;

  decompress_csr dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .val(val), .col(col), .row(row),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
    .row_ready(row_ready), .output_array(output_array),
    .valid_output(valid_output), .busy(busy), .error(error)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_csr(input int v0, input int v1, input int v2,
                         input int c0, input int c1, input int c2,
                         input int r0, input int r1, input int r2, input int r3);
    for (int i = 0; i < SIZE_OUT; i++) begin
      val[i] = '0;
      col[i] = '0;
    end
    val[0] = 8'(v0); val[1] = 8'(v1); val[2] = 8'(v2);
    col[0] = 10'(c0); col[1] = 10'(c1); col[2] = 10'(c2);
    row[0] = 18'(r0); row[1] = 18'(r1); row[2] = 18'(r2); row[3] = 18'(r3);
  endtask

  task automatic set_basic_expect();
    exp_m[0][0] = 14'sd0;  exp_m[0][1] = 14'sd5; exp_m[0][2] = 14'sd0;
    exp_m[1][0] = 14'sd0;  exp_m[1][1] = 14'sd0; exp_m[1][2] = 14'sd0;
    exp_m[2][0] = -14'sd3; exp_m[2][1] = 14'sd0; exp_m[2][2] = 14'sd7;
  endtask

  // start is sampled at the edge this task waits on (edge 0)
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int max_edges, input int stall, input int frz_at,
                     input int frz_len, output int done_edge);
    logic signed [13:0] ref0 [W_OUT];
    logic               have_ref;
    nrows = 0;
    stall_bad = 0;
    have_ref = 1'b0;
    done_edge = -1;
    for (int e = 1; e <= max_edges; e++) begin
      enable = !(e >= frz_at && e < frz_at + frz_len);
      if (row_valid && row_idx == 2'd0 && stall > 0) begin
        row_ready = 1'b0;
        stall--;
        if (!have_ref) begin
          for (int j = 0; j < W_OUT; j++) ref0[j] = row_data[j];
          have_ref = 1'b1;
        end
        for (int j = 0; j < W_OUT; j++)
          if (row_data[j] !== ref0[j]) stall_bad++;
        if (row_idx !== 2'd0) stall_bad++;
      end else begin
        row_ready = 1'b1;
      end
      if (row_valid && row_ready && enable && nrows < 8) begin
        for (int j = 0; j < W_OUT; j++) got_data[nrows][j] = row_data[j];
        got_idx[nrows]  = row_idx;
        got_edge[nrows] = e - 1;
        nrows++;
      end
      @(posedge clk);
      #1;
      if (valid_output || error) begin
        done_edge = e;
        break;
      end
    end
    enable = 1'b1;
    row_ready = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (valid_output !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", valid_output); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b expected 0", error); end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_row_valid got %b expected 0", row_valid); end
    checks++; if (row_idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_row_idx got %0d expected 0", row_idx); end
    for (int i = 0; i < H_OUT; i++)
      for (int j = 0; j < W_OUT; j++) begin
        checks++;
        if (output_array[i][j] !== 14'sd0) begin
          errors++; $display("[TB] FAIL reset_array[%0d][%0d] got %0d expected 0", i, j, output_array[i][j]);
        end
      end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int de;
    int exp_edge [3];
    exp_edge[0] = 2; exp_edge[1] = 3; exp_edge[2] = 6;
    set_csr(5, -3, 7, 1, 0, 2, 0, 1, 1, 3);
    set_basic_expect();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_load got %b expected 1", busy); end
    run(20, 0, 0, 0, de);
    checks++; if (de !== 7) begin errors++; $display("[TB] FAIL basic_done_edge got %0d expected 7", de); end
    checks++; if (nrows !== 3) begin errors++; $display("[TB] FAIL basic_nrows got %0d expected 3", nrows); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_idx[i] !== 2'(i)) begin errors++; $display("[TB] FAIL basic_row_idx[%0d] got %0d expected %0d", i, got_idx[i], i); end
      checks++;
      if (got_edge[i] !== exp_edge[i]) begin errors++; $display("[TB] FAIL basic_row_edge[%0d] got %0d expected %0d", i, got_edge[i], exp_edge[i]); end
      for (int j = 0; j < W_OUT; j++) begin
        checks++;
        if (got_data[i][j] !== exp_m[i][j]) begin errors++; $display("[TB] FAIL basic_row_data[%0d][%0d] got %0d expected %0d", i, j, got_data[i][j], exp_m[i][j]); end
        checks++;
        if (output_array[i][j] !== exp_m[i][j]) begin errors++; $display("[TB] FAIL basic_array[%0d][%0d] got %0d expected %0d", i, j, output_array[i][j], exp_m[i][j]); end
      end
    end
    checks++; if (output_array[2][0] !== 14'h3FFD) begin errors++; $display("[TB] FAIL basic_sign_ext got %h expected 3ffd", output_array[2][0]); end
    checks++; if (busy !== 1'b0 || row_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_flags got busy=%b row_valid=%b expected 0 0", busy, row_valid); end
  endtask

  task automatic test_backpressure();
    int de;
    set_csr(5, -3, 7, 1, 0, 2, 0, 1, 1, 3);
    pulse_start();
    run(30, 4, 0, 0, de);
    checks++; if (de !== 11) begin errors++; $display("[TB] FAIL bp_done_edge got %0d expected 11", de); end
    checks++; if (stall_bad !== 0) begin errors++; $display("[TB] FAIL bp_stable got %0d changes expected 0", stall_bad); end
    checks++; if (got_data[0][1] !== 14'sd5) begin errors++; $display("[TB] FAIL bp_row0 got %0d expected 5", got_data[0][1]); end
    checks++; if (valid_output !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid got %b expected 1", valid_output); end
  endtask

  task automatic test_all_zero();
    int de;
    set_csr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    run(20, 0, 0, 0, de);
    checks++; if (de !== 4) begin errors++; $display("[TB] FAIL zero_done_edge got %0d expected 4", de); end
    checks++; if (nrows !== 3) begin errors++; $display("[TB] FAIL zero_nrows got %0d expected 3", nrows); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_edge[i] !== i + 1) begin errors++; $display("[TB] FAIL zero_emit_edge[%0d] got %0d expected %0d", i, got_edge[i], i + 1); end
      for (int j = 0; j < W_OUT; j++) begin
        checks++;
        if (got_data[i][j] !== 14'sd0) begin errors++; $display("[TB] FAIL zero_row[%0d][%0d] got %0d expected 0", i, j, got_data[i][j]); end
      end
    end
  endtask

  task automatic test_malformed();
    int de;
    set_csr(5, -3, 7, 1, 0, 2, 0, 2, 1, 3);
    pulse_start();
    run(20, 0, 0, 0, de);
    checks++; if (de !== 1) begin errors++; $display("[TB] FAIL bad_ptr_err_edge got %0d expected 1", de); end
    tick(1);
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL bad_ptr_error got %b expected 1", error); end
    checks++; if (valid_output !== 1'b0 || row_valid !== 1'b0) begin errors++; $display("[TB] FAIL bad_ptr_flags got valid=%b row_valid=%b expected 0 0", valid_output, row_valid); end
    checks++; if (nrows !== 0) begin errors++; $display("[TB] FAIL bad_ptr_rows got %0d expected 0", nrows); end
    set_csr(5, -3, 7, 1, 0, 2, 0, 1, 1, 3);
    pulse_start();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL recover_error_clear got %b expected 0", error); end
    run(20, 0, 0, 0, de);
    checks++; if (de !== 7 || valid_output !== 1'b1) begin errors++; $display("[TB] FAIL recover_done got edge=%0d valid=%b expected 7 1", de, valid_output); end
    checks++; if (output_array[2][2] !== 14'sd7) begin errors++; $display("[TB] FAIL recover_array got %0d expected 7", output_array[2][2]); end
  endtask

  task automatic test_bad_col_and_dup();
    int de;
    set_csr(5, -3, 7, 3, 0, 2, 0, 1, 1, 3);
    pulse_start();
    run(20, 0, 0, 0, de);
    checks++; if (de !== 2 || error !== 1'b1) begin errors++; $display("[TB] FAIL bad_col_err got edge=%0d error=%b expected 2 1", de, error); end
    checks++; if (nrows !== 0) begin errors++; $display("[TB] FAIL bad_col_rows got %0d expected 0", nrows); end
    set_csr(2, 9, 0, 1, 1, 0, 0, 2, 2, 2);
    pulse_start();
    run(20, 0, 0, 0, de);
    checks++; if (de !== 6) begin errors++; $display("[TB] FAIL dup_done_edge got %0d expected 6", de); end
    checks++;
    if (got_data[0][0] !== 14'sd0 || got_data[0][1] !== 14'sd9 || got_data[0][2] !== 14'sd0) begin
      errors++; $display("[TB] FAIL dup_row0 got {%0d,%0d,%0d} expected {0,9,0}", got_data[0][0], got_data[0][1], got_data[0][2]);
    end
  endtask

  task automatic test_freeze_and_reset();
    int de;
    set_csr(5, -3, 7, 1, 0, 2, 0, 1, 1, 3);
    pulse_start();
    run(30, 0, 2, 3, de);
    checks++; if (de !== 10) begin errors++; $display("[TB] FAIL freeze_done_edge got %0d expected 10", de); end
    checks++; if (output_array[0][1] !== 14'sd5 || output_array[2][0] !== -14'sd3) begin errors++; $display("[TB] FAIL freeze_array got %0d %0d expected 5 -3", output_array[0][1], output_array[2][0]); end
    pulse_start();
    tick(2);
    checks++; if (row_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_emit got %b expected 1", row_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (row_valid !== 1'b0 || busy !== 1'b0 || valid_output !== 1'b0 || error !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_async_flags got rv=%b busy=%b vo=%b err=%b expected 0 0 0 0", row_valid, busy, valid_output, error);
    end
    checks++; if (row_data[1] !== 14'sd0 || row_idx !== 2'd0) begin errors++; $display("[TB] FAIL rst_async_row got data=%0d idx=%0d expected 0 0", row_data[1], row_idx); end
    reset = 1'b0;
    tick(4);
    checks++; if (valid_output !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_stays_idle got vo=%b busy=%b expected 0 0", valid_output, busy); end
  endtask

  initial begin
    for (int i = 0; i < SIZE_OUT; i++) begin
      val[i] = '0;
      col[i] = '0;
    end
    for (int k = 0; k <= H_OUT; k++) row[k] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_all_zero();
    test_malformed();
    test_bad_col_and_dup();
    test_freeze_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
